// File: rtl/nibble_entry_reg_if.sv
// Bus between the operator-input side and the nibble entry register.
// The master drives the command strobes and data; the slave (the register) drives the outputs.
interface nibble_entry_reg_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
);
    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic             load_en;
    logic [WIDTH-1:0] in;
    logic [CW-1:0]    sel;
    logic             sel_wr;
    logic             digit_wr;
    logic [DIGIT-1:0] switches;
    logic             clear;
    logic             commit;
    logic             abort;
    logic [WIDTH-1:0] x_out;
    logic [WIDTH-1:0] work;
    logic [CW-1:0]    cursor;
    logic             editing;
    logic             out_valid;

    modport master (
        output load_en, in, sel, sel_wr, digit_wr, switches, clear, commit, abort,
        input  x_out, work, cursor, editing, out_valid
    );

    modport slave (
        input  load_en, in, sel, sel_wr, digit_wr, switches, clear, commit, abort,
        output x_out, work, cursor, editing, out_valid
    );
endinterface

// File: rtl/nibble_entry_reg.sv
// Operator entry register: a working copy is edited one DIGIT-wide field at a time under a
// cursor, and only an explicit commit or parallel load publishes it to x_out.
module nibble_entry_reg #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DIGIT    = 4,
    parameter bit          AUTO_INC = 1'b1
) (
    input logic               clk,
    input logic               reset,
    nibble_entry_reg_if.slave bus
);
    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [0:0] {StIdle, StEdit} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] x_out_q;
    logic [WIDTH-1:0] work_q;
    logic [CW-1:0]    cursor_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] work_wr;
    logic [CW-1:0]    cursor_inc;
    logic             sel_ok;

    // Candidate values for a digit write: work with field[cursor] replaced, and the wrapped cursor.
    always_comb begin
        work_wr = work_q;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (cursor_q == CW'(k)) begin
                work_wr[k*DIGIT +: DIGIT] = bus.switches;
            end
        end
        cursor_inc = (cursor_q == CW'(NDIG - 1)) ? '0 : cursor_q + 1'b1;
        // Out-of-range field indices are dropped rather than aliased onto a real field.
        sel_ok     = 32'(bus.sel) < NDIG;
    end

    // Command decode and all state: one command per cycle, highest priority wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            x_out_q     <= '0;
            work_q      <= '0;
            cursor_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (bus.load_en) begin
                x_out_q     <= bus.in;
                work_q      <= bus.in;
                cursor_q    <= '0;
                state_q     <= StIdle;
                out_valid_q <= 1'b1;
            end else if (bus.abort) begin
                work_q   <= x_out_q;
                cursor_q <= '0;
                state_q  <= StIdle;
            end else if (bus.commit) begin
                // Pulses even from IDLE, where x_out keeps its value.
                x_out_q     <= work_q;
                cursor_q    <= '0;
                state_q     <= StIdle;
                out_valid_q <= 1'b1;
            end else if (bus.clear) begin
                work_q   <= '0;
                cursor_q <= '0;
                state_q  <= StEdit;
            end else if (bus.sel_wr) begin
                if (sel_ok) begin
                    cursor_q <= bus.sel;
                end
            end else if (bus.digit_wr) begin
                work_q  <= work_wr;
                state_q <= StEdit;
                if (AUTO_INC) begin
                    cursor_q <= cursor_inc;
                end
            end
        end
    end

    assign bus.x_out     = x_out_q;
    assign bus.work      = work_q;
    assign bus.cursor    = cursor_q;
    assign bus.editing   = (state_q == StEdit);
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_nibble_entry_reg.sv
// Bench for nibble_entry_reg: two instances (16-bit auto-advance, 12-bit fixed cursor) share one
// stimulus stream and are checked every cycle against a behavioural model, plus literal checks.
module tb_nibble_entry_reg;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic        load_en  = 1'b0;
    logic [15:0] din      = '0;
    logic [1:0]  sel      = '0;
    logic        sel_wr   = 1'b0;
    logic        digit_wr = 1'b0;
    logic [3:0]  switches = '0;
    logic        clear    = 1'b0;
    logic        commit   = 1'b0;
    logic        abort    = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_entry_reg_if #(.WIDTH(16), .DIGIT(4)) ifa ();
    nibble_entry_reg_if #(.WIDTH(12), .DIGIT(4)) ifb ();

    assign ifa.load_en = load_en;   assign ifb.load_en  = load_en;
    assign ifa.in      = din;       assign ifb.in       = din[11:0];
    assign ifa.sel     = sel;       assign ifb.sel      = sel;
    assign ifa.sel_wr  = sel_wr;    assign ifb.sel_wr   = sel_wr;
    assign ifa.digit_wr = digit_wr; assign ifb.digit_wr = digit_wr;
    assign ifa.switches = switches; assign ifb.switches = switches;
    assign ifa.clear   = clear;     assign ifb.clear    = clear;
    assign ifa.commit  = commit;    assign ifb.commit   = commit;
    assign ifa.abort   = abort;     assign ifb.abort    = abort;

    nibble_entry_reg #(.WIDTH(16), .DIGIT(4), .AUTO_INC(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    nibble_entry_reg #(.WIDTH(12), .DIGIT(4), .AUTO_INC(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    // Behavioural model: value-level view of the register, one struct per instance.
    typedef struct {
        logic [15:0] x;
        logic [15:0] work;
        int          cur;
        bit          edit;
        bit          valid;
    } mdl_t;

    mdl_t ma = '{x: '0, work: '0, cur: 0, edit: 1'b0, valid: 1'b0};
    mdl_t mb = '{x: '0, work: '0, cur: 0, edit: 1'b0, valid: 1'b0};

    function automatic mdl_t model_reset();
        mdl_t r;
        r.x = '0; r.work = '0; r.cur = 0; r.edit = 1'b0; r.valid = 1'b0;
        return r;
    endfunction

    function automatic mdl_t model_next(mdl_t m, int ndig, bit ainc);
        mdl_t        n = m;
        logic [15:0] mask = 16'((32'h1 << (ndig * 4)) - 1);
        logic [15:0] fmask = 16'(32'hF << (4 * m.cur));
        n.valid = 1'b0;
        if (load_en) begin
            n.x = din & mask; n.work = din & mask; n.cur = 0; n.edit = 1'b0; n.valid = 1'b1;
        end else if (abort) begin
            n.work = m.x; n.cur = 0; n.edit = 1'b0;
        end else if (commit) begin
            n.x = m.work; n.cur = 0; n.edit = 1'b0; n.valid = 1'b1;
        end else if (clear) begin
            n.work = '0; n.cur = 0; n.edit = 1'b1;
        end else if (sel_wr) begin
            if (int'(sel) < ndig) n.cur = int'(sel);
        end else if (digit_wr) begin
            n.work = (m.work & ~fmask) | 16'(32'(switches) << (4 * m.cur));
            n.edit = 1'b1;
            if (ainc) n.cur = (m.cur + 1) % ndig;
        end
        return n;
    endfunction

    // Model advances on the same edges the DUT reacts to.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ma <= model_reset();
            mb <= model_reset();
        end else begin
            ma <= model_next(ma, 4, 1'b1);
            mb <= model_next(mb, 3, 1'b0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, away from the rising edge, compare both instances with the model.
    always @(negedge clk) begin
        chk("a_x_out",     32'(ifa.x_out),     32'(ma.x));
        chk("a_work",      32'(ifa.work),      32'(ma.work));
        chk("a_cursor",    32'(ifa.cursor),    32'(ma.cur));
        chk("a_editing",   32'(ifa.editing),   32'(ma.edit));
        chk("a_out_valid", 32'(ifa.out_valid), 32'(ma.valid));
        chk("b_x_out",     32'(ifb.x_out),     32'(mb.x));
        chk("b_work",      32'(ifb.work),      32'(mb.work));
        chk("b_cursor",    32'(ifb.cursor),    32'(mb.cur));
        chk("b_editing",   32'(ifb.editing),   32'(mb.edit));
        chk("b_out_valid", 32'(ifb.out_valid), 32'(mb.valid));
    end

    task automatic clr_in();
        load_en = 1'b0; sel_wr = 1'b0; digit_wr = 1'b0;
        clear = 1'b0; commit = 1'b0; abort = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_digit(input logic [3:0] d);
        clr_in(); digit_wr = 1'b1; switches = d; step(); clr_in();
    endtask

    task automatic do_sel(input logic [1:0] s);
        clr_in(); sel_wr = 1'b1; sel = s; step(); clr_in();
    endtask

    initial begin
        clr_in();
        step(); step();
        chk("rst_x_out",     32'(ifa.x_out),     32'h0);
        chk("rst_work",      32'(ifa.work),      32'h0);
        chk("rst_cursor",    32'(ifa.cursor),    32'h0);
        chk("rst_editing",   32'(ifa.editing),   32'h0);
        chk("rst_out_valid", 32'(ifa.out_valid), 32'h0);
        reset = 1'b0;
        step();

        // Four digits wrap the cursor, then commit publishes.
        do_digit(4'hA); do_digit(4'hB); do_digit(4'hC); do_digit(4'hD);
        chk("dig4_work",    32'(ifa.work),    32'hDCBA);
        chk("dig4_cursor",  32'(ifa.cursor),  32'h0);
        chk("dig4_editing", 32'(ifa.editing), 32'h1);
        chk("dig4_x_out",   32'(ifa.x_out),   32'h0);
        commit = 1'b1; step(); clr_in();
        chk("commit_x_out",   32'(ifa.x_out),     32'hDCBA);
        chk("commit_valid",   32'(ifa.out_valid), 32'h1);
        chk("commit_editing", 32'(ifa.editing),   32'h0);
        step();
        chk("commit_valid_drop", 32'(ifa.out_valid), 32'h0);

        // Explicit cursor select, edit, then abort.
        load_en = 1'b1; din = 16'h1234; step(); clr_in();
        do_sel(2'd2);
        do_digit(4'hF);
        chk("sel_work",   32'(ifa.work),   32'h1F34);
        chk("sel_cursor", 32'(ifa.cursor), 32'h3);
        abort = 1'b1; step(); clr_in();
        chk("abort_work",   32'(ifa.work),      32'h1234);
        chk("abort_cursor", 32'(ifa.cursor),    32'h0);
        chk("abort_x_out",  32'(ifa.x_out),     32'h1234);
        chk("abort_valid",  32'(ifa.out_valid), 32'h0);

        // Fifth write after a wrap overwrites field 0.
        clear = 1'b1; step(); clr_in();
        do_digit(4'h1); do_digit(4'h2); do_digit(4'h3); do_digit(4'h4); do_digit(4'h9);
        chk("wrap_work",   32'(ifa.work),   32'h4329);
        chk("wrap_cursor", 32'(ifa.cursor), 32'h1);

        // load_en outranks commit and digit_wr in the same cycle.
        load_en = 1'b1; din = 16'h5A5A; commit = 1'b1; digit_wr = 1'b1; switches = 4'hF;
        step(); clr_in();
        chk("prio_x_out",  32'(ifa.x_out),     32'h5A5A);
        chk("prio_work",   32'(ifa.work),      32'h5A5A);
        chk("prio_cursor", 32'(ifa.cursor),    32'h0);
        chk("prio_valid",  32'(ifa.out_valid), 32'h1);
        step();
        chk("prio_valid_drop", 32'(ifa.out_valid), 32'h0);

        // 12-bit fixed-cursor instance: out-of-range select ignored, writes stay in one field.
        do_sel(2'd3);
        chk("b_sel3_cursor", 32'(ifb.cursor), 32'h0);
        do_sel(2'd1);
        do_digit(4'h7); do_digit(4'h7); do_digit(4'h7);
        chk("b_fix_work",   32'(ifb.work),   32'hA7A);
        chk("b_fix_cursor", 32'(ifb.cursor), 32'h1);

        // Asynchronous reset between edges in the middle of an edit.
        clear = 1'b1; step(); clr_in();
        do_digit(4'hB); do_digit(4'hA);
        chk("pre_rst_work", 32'(ifa.work), 32'h00AB);
        #2 reset = 1'b1;
        #1;
        chk("arst_x_out",   32'(ifa.x_out),     32'h0);
        chk("arst_work",    32'(ifa.work),      32'h0);
        chk("arst_cursor",  32'(ifa.cursor),    32'h0);
        chk("arst_editing", 32'(ifa.editing),   32'h0);
        chk("arst_valid",   32'(ifa.out_valid), 32'h0);
        step();
        reset = 1'b0;
        do_digit(4'h5);
        chk("post_rst_work",   32'(ifa.work),   32'h0005);
        chk("post_rst_cursor", 32'(ifa.cursor), 32'h1);

        // Random phase: overlapping strobes exercise priority; rare mid-cycle reset pulses.
        for (int i = 0; i < 3000; i++) begin
            clr_in();
            din      = 16'($urandom);
            sel      = 2'($urandom_range(0, 3));
            switches = 4'($urandom);
            load_en  = ($urandom_range(0, 19) == 0);
            abort    = ($urandom_range(0, 19) == 0);
            commit   = ($urandom_range(0, 11) == 0);
            clear    = ($urandom_range(0, 19) == 0);
            sel_wr   = ($urandom_range(0, 5) == 0);
            digit_wr = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b1;
                #2 reset = 1'b0;
            end
            step();
        end
        clr_in();
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nibble_entry_reg.md
# nibble_entry_reg

Parametrised successor to the team's switch-driven 16-bit entry register. The operator edits a working copy of a WIDTH-bit value one DIGIT-wide field at a time, with a cursor that is either selected explicitly or auto-advanced with wrap-around. The published output changes only on an explicit commit or a parallel load, and a one-cycle valid pulse accompanies each change. It sits between the debounced board inputs (switches, buttons) and the datapath registers that consume operator-entered operands.

## Interface
Parameters:
- WIDTH, 16, total register width; must be a multiple of DIGIT.
- DIGIT, 4, field width written per digit_wr.
- AUTO_INC, 1, 1 = cursor advances after each digit write; 0 = cursor holds.
- Derived: NDIG = WIDTH/DIGIT; CW = max(1, clog2(NDIG)).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- load_en  in  1  parallel load strobe.
- in  in  WIDTH  parallel load data.
- sel  in  CW  field index for sel_wr.
- sel_wr  in  1  cursor <= sel.
- digit_wr  in  1  write switches into field[cursor] of work.
- switches  in  DIGIT  digit value.
- clear  in  1  zero work, cursor <= 0.
- commit  in  1  publish work to x_out.
- abort  in  1  discard edits, work <= x_out.
- x_out  out  WIDTH  published value.
- work  out  WIDTH  working copy for display.
- cursor  out  CW  current field index.
- editing  out  1  high in EDIT state.
- out_valid  out  1  one-cycle pulse when x_out is updated.

## Operation
- Field k occupies work[k*DIGIT +: DIGIT]. Field 0 is the least significant.
- The state machine has two states, IDLE and EDIT. In IDLE, work == x_out always holds.
- Each cycle at most one command acts. Priority: load_en > abort > commit > clear > sel_wr > digit_wr. Lower-priority strobes asserted in the same cycle are ignored and have no deferred effect.
- load_en: x_out <= in, work <= in, cursor <= 0, state <= IDLE, out_valid <= 1. This applies in any state.
- abort: work <= x_out, cursor <= 0, state <= IDLE. x_out is unchanged and out_valid stays 0.
- commit: x_out <= work, out_valid <= 1, state <= IDLE, cursor <= 0. A commit in IDLE still pulses out_valid, with x_out unchanged in value.
- clear: work <= 0, cursor <= 0, state <= EDIT.
- sel_wr: cursor <= sel if sel < NDIG; otherwise the command is ignored entirely. state is unchanged.
- digit_wr: field[cursor] of work <= switches, state <= EDIT. If AUTO_INC=1, cursor <= (cursor == NDIG-1) ? 0 : cursor+1.
- x_out changes only on load_en or commit.
- editing = (state == EDIT).

## Timing
- All outputs are registered. Each command takes effect on the rising edge where it is sampled high, and the new values are visible in the following cycle.
- out_valid is high for exactly the one cycle in which the new x_out is first visible. Back-to-back commits give back-to-back pulses.
- Strobes are level-sampled every cycle. Holding digit_wr high for N cycles performs N writes, advancing the cursor N times when AUTO_INC=1.
- Reset values, applied asynchronously: x_out=0, work=0, cursor=0, editing=0 (IDLE), out_valid=0.
- Reset mid-edit discards work and returns to IDLE. There is no recovery of partial edits.
- Cursor wrap: with AUTO_INC=1, a write at field NDIG-1 wraps the cursor to 0. Further writes overwrite the earlier fields.

## Test plan
- Reset, then 4× digit_wr with switches = A, B, C, D (WIDTH=16) -> work=0xDCBA, cursor=0 after the wrap, editing=1, x_out=0, out_valid never high. Then commit -> x_out=0xDCBA, out_valid high for 1 cycle, editing=0.
- With x_out=0x1234: sel_wr sel=2, digit_wr 0xF -> work=0x1F34, cursor=3. Then abort -> work=0x1234, cursor=0, x_out unchanged, no out_valid.
- 5th digit_wr after four writes of 1, 2, 3, 4, with switches=9 -> work=0x4329 (field 0 overwritten), cursor=1.
- Same cycle: load_en with in=0x5A5A, plus commit and digit_wr -> x_out=work=0x5A5A, cursor=0, one out_valid pulse, digit write discarded.
- WIDTH=12, AUTO_INC=0: sel_wr sel=3 -> cursor unchanged. Then 3× digit_wr with switches=7 -> only field[cursor] changes, cursor constant.
- Assert reset asynchronously mid-edit, between clock edges, with work=0x00AB -> all outputs zero immediately, IDLE; the next digit_wr writes field 0.
